// File: rtl/cnn_mac_pipe_if.sv
// Term-in / result-out handshake bundle for cnn_mac_pipe.
// master = term producer / result consumer side; slave = the MAC pipe.
interface cnn_mac_pipe_if #(
  parameter int A_WIDTH    = 14,
  parameter int B_WIDTH    = 7,
  parameter int DOUT_WIDTH = 16
);
  logic                  in_vld;
  logic                  in_rdy;
  logic [A_WIDTH-1:0]    in_a;
  logic [B_WIDTH-1:0]    in_b;
  logic                  in_last;
  logic                  out_vld;
  logic                  out_rdy;
  logic [DOUT_WIDTH-1:0] out_data;
  logic                  out_sat;

  modport master (
    output in_vld, in_a, in_b, in_last, out_rdy,
    input  in_rdy, out_vld, out_data, out_sat
  );

  modport slave (
    input  in_vld, in_a, in_b, in_last, out_rdy,
    output in_rdy, out_vld, out_data, out_sat
  );
endinterface

// File: rtl/cnn_mac_pipe.sv
// Pipelined signed MAC: register inputs, multiply, accumulate over a window,
// then scale / rectify / saturate and hand one result per window downstream.
module cnn_mac_pipe #(
  parameter int A_WIDTH    = 14,
  parameter int B_WIDTH    = 7,
  parameter int B_SIGNED   = 0,
  parameter int ACC_WIDTH  = 32,
  parameter int SHIFT      = 0,
  parameter int DOUT_WIDTH = 16,
  parameter int RELU       = 0
) (
  input logic           ap_clk,
  input logic           ap_rst_n,
  cnn_mac_pipe_if.slave bus
);
  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] MAX_V =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_V =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

  logic                         en;
  logic                         s1_vld, s1_last, s2_vld, s2_last;
  logic signed [A_WIDTH-1:0]    s1_a;
  logic        [B_WIDTH-1:0]    s1_b;
  logic signed [B_WIDTH:0]      b_ext;
  logic signed [P_WIDTH-1:0]    prod, s2_p;
  logic signed [ACC_WIDTH-1:0]  acc, sum, shifted, rect;
  logic        [DOUT_WIDTH-1:0] clamp_data;
  logic                         clamp_sat;
  logic                         out_vld, out_sat;
  logic        [DOUT_WIDTH-1:0] out_data;

  assign en           = !out_vld || bus.out_rdy;
  assign bus.in_rdy   = en;
  assign bus.out_vld  = out_vld;
  assign bus.out_data = out_data;
  assign bus.out_sat  = out_sat;

  // Unsigned weights gain a zero MSB so the signed multiply stays exact.
  assign b_ext   = (B_SIGNED != 0) ? {s1_b[B_WIDTH-1], s1_b} : {1'b0, s1_b};
  assign prod    = s1_a * b_ext;
  assign sum     = acc + ACC_WIDTH'(s2_p);
  assign shifted = sum >>> SHIFT;

  always_comb begin
    rect       = shifted;
    clamp_sat  = 1'b0;
    clamp_data = '0;
    if (RELU != 0 && shifted < 0) rect = '0;
    if (rect > MAX_V) begin
      clamp_data = MAX_V[DOUT_WIDTH-1:0];
      clamp_sat  = 1'b1;
    end else if (rect < MIN_V) begin
      clamp_data = MIN_V[DOUT_WIDTH-1:0];
      clamp_sat  = 1'b1;
    end else begin
      clamp_data = rect[DOUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (en) begin
      s1_a    <= bus.in_a;
      s1_b    <= bus.in_b;
      s1_last <= bus.in_last;
      s2_p    <= prod;
      s2_last <= s1_last;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
      acc      <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (en) begin
      s1_vld <= bus.in_vld;
      s2_vld <= s1_vld;
      if (s2_vld && s2_last) begin
        acc      <= '0;
        out_data <= clamp_data;
        out_sat  <= clamp_sat;
        out_vld  <= 1'b1;
      end else begin
        if (s2_vld) acc <= sum;
        // en with out_vld high implies out_rdy, so a held result drains here
        out_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Bench for cnn_mac_pipe: three parameterisations share one term stream and
// are checked against a window-level arithmetic model plus directed values.
module tb_cnn_mac_pipe;
  logic       ap_clk;
  logic       ap_rst_n;
  logic       vld, last, ordy;
  logic [13:0] a;
  logic [6:0]  b;

  int checks   = 0;
  int failures = 0;

  cnn_mac_pipe_if bus0 ();
  cnn_mac_pipe_if bus1 ();
  cnn_mac_pipe_if bus2 ();

  assign bus0.in_vld = vld;  assign bus0.in_a = a;  assign bus0.in_b = b;
  assign bus0.in_last = last; assign bus0.out_rdy = ordy;
  assign bus1.in_vld = vld;  assign bus1.in_a = a;  assign bus1.in_b = b;
  assign bus1.in_last = last; assign bus1.out_rdy = ordy;
  assign bus2.in_vld = vld;  assign bus2.in_a = a;  assign bus2.in_b = b;
  assign bus2.in_last = last; assign bus2.out_rdy = ordy;

  cnn_mac_pipe dut0 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus0.slave));
  cnn_mac_pipe #(.B_SIGNED(1)) dut1 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus1.slave));
  cnn_mac_pipe #(.RELU(1), .SHIFT(2)) dut2 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus2.slave));

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Reference state: terms of the open window and expected {sat,data} per DUT.
  int          wa[$];
  int          wb[$];
  logic [16:0] q0[$], q1[$], q2[$];
  int          del0[$];
  int          last0, last1, last2;
  int          sat0, sat2;
  bit          hold_pend;
  int          hold_data;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model(input bit bs, input bit relu, input int sh);
    longint s = 0;
    int     s32;
    longint v;
    logic   sat = 1'b0;
    foreach (wa[i]) s += longint'(wa[i]) * longint'((bs && wb[i] >= 64) ? wb[i] - 128 : wb[i]);
    s32 = int'(s);
    v = longint'(s32 >>> sh);
    if (relu && v < 0) v = 0;
    if (v > 32767) begin v = 32767; sat = 1'b1; end
    else if (v < -32768) begin v = -32768; sat = 1'b1; end
    return {sat, 16'(v)};
  endfunction

  // Sample shortly after the falling edge, update model, advance one cycle.
  task automatic tick(output bit accepted);
    logic [16:0] e;
    accepted = 1'b0;
    #1;
    if (!ap_rst_n) begin
      wa.delete(); wb.delete(); q0.delete(); q1.delete(); q2.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_vld", int'(bus0.out_vld), 1);
        chk("hold_data", int'($signed(bus0.out_data)), hold_data);
      end
      hold_pend = bus0.out_vld && !ordy;
      hold_data = int'($signed(bus0.out_data));
      if (bus0.out_vld && ordy) begin
        e = (q0.size() > 0) ? q0.pop_front() : 17'h1ffff;
        last0 = int'($signed(bus0.out_data)); sat0 = int'(bus0.out_sat);
        del0.push_back(last0);
        chk("res0_data", last0, int'($signed(e[15:0])));
        chk("res0_sat", sat0, int'(e[16]));
      end
      if (bus1.out_vld && ordy) begin
        e = (q1.size() > 0) ? q1.pop_front() : 17'h1ffff;
        last1 = int'($signed(bus1.out_data));
        chk("res1_data", last1, int'($signed(e[15:0])));
        chk("res1_sat", int'(bus1.out_sat), int'(e[16]));
      end
      if (bus2.out_vld && ordy) begin
        e = (q2.size() > 0) ? q2.pop_front() : 17'h1ffff;
        last2 = int'($signed(bus2.out_data)); sat2 = int'(bus2.out_sat);
        chk("res2_data", last2, int'($signed(e[15:0])));
        chk("res2_sat", sat2, int'(e[16]));
      end
      if (vld && bus0.in_rdy) begin
        accepted = 1'b1;
        wa.push_back(int'($signed(a)));
        wb.push_back(int'(b));
        if (last) begin
          q0.push_back(model(1'b0, 1'b0, 0));
          q1.push_back(model(1'b1, 1'b0, 0));
          q2.push_back(model(1'b0, 1'b1, 2));
          wa.delete(); wb.delete();
        end
      end
    end
    @(posedge ap_clk);
    @(negedge ap_clk);
  endtask

  task automatic send(input int av, input int bv, input bit lv);
    bit ok = 1'b0;
    vld = 1'b1; a = 14'(av); b = 7'(bv); last = lv;
    for (int i = 0; i < 50 && !ok; i++) tick(ok);
    if (!ok) chk("send_timeout", int'(ok), 1);
    vld = 1'b0; last = 1'b0;
  endtask

  task automatic idle(input int n);
    bit d;
    for (int i = 0; i < n; i++) tick(d);
  endtask

  task automatic drain();
    bit d;
    ordy = 1'b1;
    for (int i = 0; i < 60 && (q0.size() + q1.size() + q2.size()) > 0; i++) tick(d);
    idle(1);
    chk("drain_pending", q0.size() + q1.size() + q2.size(), 0);
  endtask

  initial begin
    vld = 1'b0; last = 1'b0; ordy = 1'b1; a = '0; b = '0;
    ap_rst_n = 1'b0;
    hold_pend = 1'b0;
    @(negedge ap_clk);
    idle(2);
    ap_rst_n = 1'b1;
    #1;
    chk("rst_out_vld", int'(bus0.out_vld), 0);
    chk("rst_out_data", int'(bus0.out_data), 0);
    chk("rst_out_sat", int'(bus0.out_sat), 0);

    // Defaults and three-cycle latency
    send(100, 3, 0); send(-50, 10, 0); send(7, 127, 1);
    #1 chk("lat_c1", int'(bus0.out_vld), 0); idle(1);
    #1 chk("lat_c2", int'(bus0.out_vld), 0); idle(1);
    #1 chk("lat_c3", int'(bus0.out_vld), 1); idle(1);
    #1 chk("lat_c4", int'(bus0.out_vld), 0);
    chk("t1_data", last0, 689);
    chk("t1_sat", sat0, 0);

    // Saturation
    send(8191, 127, 0); send(8191, 127, 1); drain();
    chk("sat_hi_data", last0, 32767); chk("sat_hi_flag", sat0, 1);
    send(-8192, 127, 1); drain();
    chk("sat_lo_data", last0, -32768); chk("sat_lo_flag", sat0, 1);

    // Modes
    send(100, 127, 1); drain();
    chk("bsigned_data", last1, -100); chk("bunsigned_data", last0, 12700);
    send(-50, 10, 1); drain();
    chk("relu_data", last2, 0); chk("relu_sat", sat2, 0);
    send(100, 3, 1); drain();
    chk("shift_data", last2, 75);

    // Backpressure
    ordy = 1'b0;
    send(2, 3, 1); send(4, 5, 1);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_vld", int'(bus0.out_vld), 1);
      chk("bp_data", int'($signed(bus0.out_data)), 6);
      chk("bp_in_rdy", int'(bus0.in_rdy), 0);
      idle(1);
    end
    del0.delete();
    drain();
    chk("bp_count", del0.size(), 2);
    chk("bp_first", (del0.size() > 0) ? del0[0] : -1, 6);
    chk("bp_second", (del0.size() > 1) ? del0[1] : -1, 20);

    // Reset mid-window
    send(9, 9, 0); send(9, 9, 0);
    ap_rst_n = 1'b0; idle(1); ap_rst_n = 1'b1;
    #1 chk("midrst_vld", int'(bus0.out_vld), 0);
    send(5, 5, 1); drain();
    chk("midrst_data", last0, 25);

    // Bubbles inside a window, then an immediate single-term window
    del0.delete();
    send(1, 1, 0); idle(3); send(2, 2, 0); idle(1); send(3, 3, 1); send(1, 1, 1);
    drain();
    chk("bub_count", del0.size(), 2);
    chk("bub_sum", (del0.size() > 0) ? del0[0] : -1, 14);
    chk("bub_next", (del0.size() > 1) ? del0[1] : -1, 1);

    // Randomised stream with random backpressure
    for (int i = 0; i < 600; i++) begin
      bit d;
      vld  = ($urandom % 10) < 7;
      a    = 14'($urandom);
      b    = 7'($urandom);
      last = ($urandom % 4) == 0;
      ordy = ($urandom % 10) < 7;
      tick(d);
    end
    vld = 1'b0; last = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
